cmp_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single WIDTH-bit magnitude comparator among NREQ requesters. Each requester presents an (a, b) operand pair under a valid/ready handshake. The block grants one requester, captures its operands, and runs the comparison. It then returns a registered Lesser/Greater/Equal result tagged with the requester index under a second valid/ready handshake. It sits between the operand-producing engines and the shared comparator datapath.

---
 rtl/cmp_arbiter.sv | 130 +++++++++++++
 tb/tb_cmp_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter sequencing NREQ requesters onto one shared magnitude comparator
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   req_valid    [NREQ]        per-requester operand-pair valid
//   req_a/req_b  [NREQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready    [NREQ]        one-hot grant, driven only in IDLE
//   rsp_valid    result available; rsp_ready accepts it
//   rsp_id       [IDW]         requester that owns the result
//   rsp_lesser / rsp_greater / rsp_equal  registered a<b / a>b / a==b
//
// Build option: define CMP_ARB_SIGNED_EN to compare operands as two's-complement
// signed values; default compares them as unsigned.

module cmp_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_lesser,
  output logic                  rsp_greater,
  output logic                  rsp_equal
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam logic [IDW:0]   NREQ_X = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDW-1:0]   op_id;

  logic             found;
  logic [IDW-1:0]   gidx;
  logic [IDW:0]     scan;
  logic             lt;
  logic             gt;
  logic             eq;

  // Round-robin pick: first set req_valid bit at or above ptr, wrapping.
  // scan is one bit wider than ptr so ptr+k never overflows before the wrap.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= NREQ_X) scan = scan - NREQ_X;
      if (!found && req_valid[scan[IDW-1:0]]) begin
        found = 1'b1;
        gidx  = scan[IDW-1:0];
      end
    end
  end

  // Grant depends only on state, ptr and req_valid, never on rsp_ready.
  // Gated by rst so nothing is accepted in a cycle that is being reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state == S_IDLE && found) req_ready[gidx] = 1'b1;
  end

`ifdef CMP_ARB_SIGNED_EN
  assign lt = $signed(op_a) < $signed(op_b);
  assign gt = $signed(op_a) > $signed(op_b);
`else
  assign lt = op_a < op_b;
  assign gt = op_a > op_b;
`endif
  assign eq = (op_a == op_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_lesser  <= 1'b0;
      rsp_greater <= 1'b0;
      rsp_equal   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            op_a  <= req_a[gidx*WIDTH +: WIDTH];
            op_b  <= req_b[gidx*WIDTH +: WIDTH];
            op_id <= gidx;
            state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          rsp_lesser  <= lt;
          rsp_greater <= gt;
          rsp_equal   <= eq;
          rsp_id      <= op_id;
          rsp_valid   <= 1'b1;
          state       <= S_RESPOND;
        end
        S_RESPOND: begin
          // rsp_* stay untouched until the consumer takes the result.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (op_id == LAST_ID) ? '0 : op_id + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - self-checking bench for cmp_arbiter against a transaction-level model

module tb_cmp_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_lesser;
  logic                  rsp_greater;
  logic                  rsp_equal;

  cmp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_lesser (rsp_lesser),
    .rsp_greater(rsp_greater),
    .rsp_equal  (rsp_equal)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Requester side: pending operand pairs.
  bit               pend_v[NREQ];
  logic [WIDTH-1:0] pend_a[NREQ];
  logic [WIDTH-1:0] pend_b[NREQ];

  // Transaction-level model of the shared comparator.
  bit               m_free = 1'b1;
  int               m_ptr  = 0;
  int               m_age  = 0;   // cycles since the grant of the job in flight
  int               m_id   = 0;
  logic [WIDTH-1:0] m_a, m_b;
  bit               m_zero = 1'b1; // rsp_* still at reset values

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Returns {lesser, greater, equal} from integer comparison.
  function automatic logic [2:0] cmp3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int x, y;
`ifdef CMP_ARB_SIGNED_EN
    x = {{(32-WIDTH){a[WIDTH-1]}}, a};
    y = {{(32-WIDTH){b[WIDTH-1]}}, b};
`else
    x = {{(32-WIDTH){1'b0}}, a};
    y = {{(32-WIDTH){1'b0}}, b};
`endif
    return {x < y, x > y, x == y};
  endfunction

  task automatic step(input bit r, input bit rr);
    int g;
    bit exp_rv;
    logic [NREQ-1:0] er;
    @(negedge clk);
    rst = r;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = pend_v[i];
      req_a[i*WIDTH +: WIDTH] = pend_a[i];
      req_b[i*WIDTH +: WIDTH] = pend_b[i];
    end
    #1;
    g = (m_free && !r) ? pick(req_valid, m_ptr) : -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    exp_rv = !m_free && (m_age >= 2);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_lge", 32'({rsp_lesser, rsp_greater, rsp_equal}), 32'(cmp3(m_a, m_b)));
      m_zero = 1'b0;
    end else if (m_zero) begin
      chk("rsp_idle_zero", 32'({rsp_id, rsp_lesser, rsp_greater, rsp_equal}), 32'd0);
    end
    @(posedge clk);
    if (r) begin
      m_free = 1'b1;
      m_ptr  = 0;
      m_zero = 1'b1;
    end else if (g >= 0) begin
      m_free = 1'b0;
      m_age  = 1;
      m_id   = g;
      m_a    = pend_a[g];
      m_b    = pend_b[g];
      pend_v[g] = 1'b0;
    end else if (!m_free) begin
      if (m_age >= 2 && rr) begin
        m_free = 1'b1;
        m_ptr  = (m_id + 1) % NREQ;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_b[i] = b;
  endtask

  task automatic drain();
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    for (int n = 0; n < 4; n++) step(1'b0, 1'b1);
  endtask

  task automatic rand_ops(output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b);
    case ($urandom_range(0, 3))
      0: begin a = WIDTH'($urandom); b = WIDTH'($urandom); end
      1: begin a = WIDTH'($urandom); b = a; end
      2: begin
        if ($urandom_range(0, 1) == 1) begin a = 16'hFFFF; b = 16'h0001; end
        else begin a = 16'h0001; b = 16'hFFFF; end
      end
      default: begin a = WIDTH'($urandom_range(0, 7)); b = WIDTH'($urandom_range(0, 7)); end
    endcase
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_b[i] = '0;
    end
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    @(posedge clk);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Single request, a<b.
    set_req(0, 16'd100, 16'd101);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b1);

    // Fairness: everyone continuously valid with a==b.
    drain();
    for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(i), WIDTH'(i));
    for (int n = 0; n < 16; n++) begin
      step(1'b0, 1'b1);
      for (int i = 0; i < NREQ; i++) if (!pend_v[i]) set_req(i, WIDTH'(i), WIDTH'(i));
    end

    // Backpressure on requester 2 while others wait.
    drain();
    set_req(2, 16'd777, 16'd111);
    step(1'b0, 1'b0);
    set_req(0, 16'd5, 16'd9);
    set_req(1, 16'd9, 16'd5);
    for (int n = 0; n < 6; n++) step(1'b0, 1'b0);
    for (int n = 0; n < 8; n++) step(1'b0, 1'b1);

    // Wrap and priority around requester 3.
    drain();
    set_req(3, 16'd1, 16'd2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    set_req(0, 16'd3, 16'd3);
    set_req(3, 16'd4, 16'd0);
    for (int n = 0; n < 8; n++) step(1'b0, 1'b1);

    // Reset during COMPARE discards the job and restarts from ptr 0.
    drain();
    set_req(2, 16'd8888, 16'd8888);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    set_req(1, 16'd2, 16'd2);
    set_req(3, 16'd7, 16'd1);
    for (int n = 0; n < 10; n++) step(1'b0, 1'b1);

    // Signedness corner.
    drain();
    set_req(1, 16'hFFFF, 16'h0001);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b1);

    // Random traffic with drops, backpressure and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_v[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            rand_ops(ra, rb);
            set_req(i, ra, rb);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend_v[i] = 1'b0;
        end
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
